// File: rtl/serial_shift_unit_if.sv
// serial_shift_unit_if: start/busy/done handshake and operand/result bus for the serial shifter
interface serial_shift_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [31:0]      shamt_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    modport master (output start, op, data_in, shamt_in, input busy, done, result);
    modport slave (input start, op, data_in, shamt_in, output busy, done, result);
endinterface

// File: rtl/serial_shift_unit.sv
// serial_shift_unit: one-bit-per-clock SLL/SRL/SRA/ROTR shifter with start/busy/done handshake
module serial_shift_unit #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
) (
    input logic clk,
    input logic rst,
    serial_shift_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                state, state_n;
    logic [WIDTH-1:0]      work, work_n, stepped, result;
    logic [SHAMT_BITS-1:0] cnt, cnt_n, s;
    logic [1:0]            op, op_n;
    logic                  load;
    always_comb begin
        s       = bus.shamt_in[SHAMT_BITS-1:0];
        stepped = op == 2'd0 ? {work[WIDTH-2:0], 1'b0} :
                  op == 2'd1 ? {1'b0, work[WIDTH-1:1]} :
                  op == 2'd2 ? {work[WIDTH-1], work[WIDTH-1:1]} :
                               {work[0], work[WIDTH-1:1]};
        load    = bus.start && state != SHIFT;
        state_n = IDLE;
        work_n  = work;
        cnt_n   = cnt;
        op_n    = op;
        if (state == SHIFT) begin
            work_n  = stepped;
            cnt_n   = cnt - SHAMT_BITS'(1);
            state_n = cnt == SHAMT_BITS'(1) ? DONE : SHIFT;
        end else if (load) begin
            work_n  = bus.data_in;
            cnt_n   = s;
            op_n    = bus.op;
            state_n = s == '0 ? DONE : SHIFT;
        end
    end
    // result is written from the value work takes on DONE entry, so it is valid while done=1
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            op     <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            work  <= work_n;
            cnt   <= cnt_n;
            op    <= op_n;
            if (state_n == DONE) result <= work_n;
        end
    end
    assign bus.busy   = state == SHIFT;
    assign bus.done   = state == DONE;
    assign bus.result = result;
endmodule

// File: tb/tb_serial_shift_unit.sv
// tb_serial_shift_unit: directed tests of the serial shifter with hand-computed results and latencies
module tb_serial_shift_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    serial_shift_unit_if #(.WIDTH(32)) bus ();
    serial_shift_unit #(.WIDTH(32), .SHAMT_BITS(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    // Drives a one-cycle start; returns at the negedge of the first cycle after the sampling edge.
    task automatic pulse_start(input logic [1:0] op, input logic [31:0] data, input logic [31:0] shamt);
        @(negedge clk);
        bus.start = 1;
        bus.op = op;
        bus.data_in = data;
        bus.shamt_in = shamt;
        @(negedge clk);
        bus.start = 0;
    endtask
    // Counts observed cycles (starting at 1) until done; 999 means it never came.
    task automatic wait_done(output int n, output int nbusy, output int overlap);
        n = 1;
        nbusy = 0;
        overlap = 0;
        while (1) begin
            if (bus.busy) nbusy++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) break;
            if (n >= 100) begin
                n = 999;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask
    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        checks += 3;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", bus.result); end
        rst = 0;
    endtask
    task automatic test_sll;
        int n, nb, ov;
        pulse_start(2'd0, 32'h1, 32'h1F);
        wait_done(n, nb, ov);
        checks += 4;
        if (n !== 32) begin failures++; $display("FAIL sll_latency got=%0d exp=32", n); end
        if (nb !== 31) begin failures++; $display("FAIL sll_busy_cycles got=%0d exp=31", nb); end
        if (ov !== 0) begin failures++; $display("FAIL sll_busy_done_overlap got=%0d exp=0", ov); end
        if (bus.result !== 32'h80000000) begin failures++; $display("FAIL sll_result got=%h exp=80000000", bus.result); end
        repeat (3) @(negedge clk);
        checks += 2;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL sll_done_pulse got=%b exp=0", bus.done); end
        if (bus.result !== 32'h80000000) begin failures++; $display("FAIL sll_result_held got=%h exp=80000000", bus.result); end
    endtask
    task automatic test_sra_srl;
        int n, nb, ov;
        pulse_start(2'd2, 32'h80000000, 32'd4);
        wait_done(n, nb, ov);
        checks += 2;
        if (n !== 5) begin failures++; $display("FAIL sra_latency got=%0d exp=5", n); end
        if (bus.result !== 32'hF8000000) begin failures++; $display("FAIL sra_result got=%h exp=F8000000", bus.result); end
        pulse_start(2'd1, 32'h80000000, 32'd4);
        wait_done(n, nb, ov);
        checks += 2;
        if (n !== 5) begin failures++; $display("FAIL srl_latency got=%0d exp=5", n); end
        if (bus.result !== 32'h08000000) begin failures++; $display("FAIL srl_result got=%h exp=08000000", bus.result); end
    endtask
    task automatic test_zero_and_upper;
        int n, nb, ov;
        pulse_start(2'd0, 32'h12345678, 32'h0);
        wait_done(n, nb, ov);
        checks += 3;
        if (n !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", n); end
        if (nb !== 0) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=0", nb); end
        if (bus.result !== 32'h12345678) begin failures++; $display("FAIL zero_result got=%h exp=12345678", bus.result); end
        pulse_start(2'd3, 32'h000000F1, 32'h23);
        wait_done(n, nb, ov);
        checks += 3;
        if (n !== 4) begin failures++; $display("FAIL rotr_latency got=%0d exp=4", n); end
        if (nb !== 3) begin failures++; $display("FAIL rotr_busy_cycles got=%0d exp=3", nb); end
        if (bus.result !== 32'h2000001E) begin failures++; $display("FAIL rotr_result got=%h exp=2000001E", bus.result); end
    endtask
    task automatic test_back_to_back;
        int n, nb, ov;
        pulse_start(2'd0, 32'h3, 32'd8);
        checks += 2;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b exp=1", bus.busy); end
        if (bus.result !== 32'h2000001E) begin failures++; $display("FAIL ignore_prev_result got=%h exp=2000001E", bus.result); end
        @(negedge clk);
        bus.start = 1;
        bus.op = 2'd1;
        bus.data_in = 32'hFFFF;
        bus.shamt_in = 32'd1;
        @(negedge clk);
        bus.start = 0;
        wait_done(n, nb, ov);
        checks += 2;
        if (n + 2 !== 9) begin failures++; $display("FAIL ignore_latency got=%0d exp=9", n + 2); end
        if (bus.result !== 32'h300) begin failures++; $display("FAIL ignore_result got=%h exp=00000300", bus.result); end
        pulse_start(2'd1, 32'h100, 32'd2);
        wait_done(n, nb, ov);
        checks += 1;
        if (bus.result !== 32'h40) begin failures++; $display("FAIL b2b_first_result got=%h exp=00000040", bus.result); end
        bus.start = 1;
        bus.op = 2'd0;
        bus.data_in = 32'h1;
        bus.shamt_in = 32'd3;
        @(negedge clk);
        bus.start = 0;
        checks += 1;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_no_gap_busy got=%b exp=1", bus.busy); end
        wait_done(n, nb, ov);
        checks += 2;
        if (n !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", n); end
        if (bus.result !== 32'h8) begin failures++; $display("FAIL b2b_second_result got=%h exp=00000008", bus.result); end
    endtask
    task automatic test_reset_mid_shift;
        int n, nb, ov, dones;
        pulse_start(2'd0, 32'h1, 32'd20);
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks += 3;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        if (bus.result !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=00000000", bus.result); end
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        checks += 1;
        if (dones !== 0) begin failures++; $display("FAIL abort_stays_idle got=%0d exp=0", dones); end
        pulse_start(2'd1, 32'hF0, 32'd4);
        wait_done(n, nb, ov);
        checks += 2;
        if (n !== 5) begin failures++; $display("FAIL after_reset_latency got=%0d exp=5", n); end
        if (bus.result !== 32'hF) begin failures++; $display("FAIL after_reset_result got=%h exp=0000000F", bus.result); end
    endtask
    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        bus.start = 0;
        bus.op = 0;
        bus.data_in = 0;
        bus.shamt_in = 0;
        test_reset;
        test_sll;
        test_sra_srl;
        test_zero_and_upper;
        test_back_to_back;
        test_reset_mid_shift;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
